// File: rtl/mmpu_pkg.sv
// mmpu_pkg: shared defaults, FSM state and opcode types for the MMPU operand loader
package mmpu_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int N_ELEM_DEF = 4;
  localparam logic [1:0] SYNC = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_CHECK} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_ADD, OP_SUB, OP_TRANSPOSE} opcode_t;
endpackage

// File: rtl/mmpu_operand_loader.sv
// mmpu_operand_loader: byte-serial frame to operand-set loader; MMPU_LOADER_CHECKSUM_EN adds an XOR checksum byte
module mmpu_operand_loader
  import mmpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_ELEM = N_ELEM_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [1:0]               op_code,
  output logic [N_ELEM*DATA_W-1:0] op_a,
  output logic [N_ELEM*DATA_W-1:0] op_b,
  output logic                     err,
  output logic                     busy
);
  localparam int CW = $clog2(2 * N_ELEM);
  localparam logic [CW-1:0] LAST = CW'(2 * N_ELEM - 1);
`ifdef MMPU_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CHECK;
`else
  localparam state_t S_AFTER = S_ISSUE;
`endif
  state_t r_st, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_code;
  logic [N_ELEM*DATA_W-1:0] r_a, r_b;
  logic r_err, w_err, w_acc, w_sync;
`ifdef MMPU_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif
  assign w_acc    = in_valid && in_ready;
  assign w_sync   = in_data[7:6] == SYNC;
  assign in_ready = r_st != S_ISSUE;
  assign op_valid = r_st == S_ISSUE;
  assign busy     = r_st != S_IDLE;
  assign op_code  = r_code;
  assign op_a     = r_a;
  assign op_b     = r_b;
  assign err      = r_err;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= S_IDLE;
    else r_st <= w_nxt;
  end
  // next state and drop-frame detection
  always_comb begin
    w_nxt = r_st;
    w_err = 1'b0;
    case (r_st)
      S_IDLE: begin
        w_nxt = w_acc && w_sync ? S_LOAD : S_IDLE;
        w_err = w_acc && !w_sync;
      end
      S_LOAD: w_nxt = w_acc && r_cnt == LAST ? S_AFTER : S_LOAD;
`ifdef MMPU_LOADER_CHECKSUM_EN
      S_CHECK: begin
        w_nxt = !w_acc ? S_CHECK : (r_sum == in_data ? S_ISSUE : S_IDLE);
        w_err = w_acc && r_sum != in_data;
      end
`endif
      S_ISSUE: w_nxt = op_ready ? S_IDLE : S_ISSUE;
      default: w_nxt = S_IDLE;
    endcase
  end
  // opcode latch, element counter, operand registers and err pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_code <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_acc && r_st == S_IDLE && w_sync) begin
        r_code <= in_data[1:0];
        r_cnt  <= '0;
      end
      if (w_acc && r_st == S_LOAD) begin
        r_cnt <= r_cnt + CW'(1);
        for (int k = 0; k < N_ELEM; k++) begin
          if (r_cnt == CW'(k)) r_a[k*DATA_W +: DATA_W] <= in_data;
          if (r_cnt == CW'(k + N_ELEM)) r_b[k*DATA_W +: DATA_W] <= in_data;
        end
      end
    end
  end
`ifdef MMPU_LOADER_CHECKSUM_EN
  // running XOR over header and operand bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sum <= '0;
    else if (w_acc) r_sum <= r_st == S_IDLE ? in_data : r_sum ^ in_data;
  end
`endif
endmodule

// File: tb/tb_mmpu_operand_loader.sv
// tb_mmpu_operand_loader: table-driven and scoreboard bench for mmpu_operand_loader
module tb_mmpu_operand_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0, in_ready, op_valid, op_ready = 1'b0, err, busy;
  logic [1:0] op_code;
  logic [31:0] op_a, op_b;
  int checks = 0, failures = 0;
  logic [65:0] q[$];
  typedef struct packed {
    logic [7:0]  hdr;
    logic [63:0] d;
    logic        tog;
    logic [3:0]  hold;
    logic [1:0]  code;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;
  vec_t vec [4];
  mmpu_operand_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .err(err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  // scoreboard: compare each transferred operand set with the oldest expected one
  always @(negedge clk) begin
    if (!rst && op_valid && op_ready) begin
      if (q.size() == 0) chk("unexpected_issue", 1, 0);
      else begin
        logic [65:0] e;
        e = q.pop_front();
        chk("op_code", {62'd0, op_code}, {62'd0, e[65:64]});
        chk("op_a", {32'd0, op_a}, {32'd0, e[63:32]});
        chk("op_b", {32'd0, op_b}, {32'd0, e[31:0]});
      end
    end
  end
  task automatic send(input logic [7:0] b, input logic tog);
    int n;
    if (tog) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic frame(input vec_t v, input logic [7:0] last, input logic last_ok);
    logic [7:0] x;
    x = v.hdr;
    q.push_back({v.code, v.a, v.b});
    send(v.hdr, v.tog);
    for (int k = 0; k < 8; k++) begin
      send(v.d[k*8 +: 8], v.tog);
      x = x ^ v.d[k*8 +: 8];
    end
`ifdef MMPU_LOADER_CHECKSUM_EN
    send(last_ok ? x : last, v.tog);
`endif
    chk("issue_valid", {63'd0, op_valid}, 1);
    chk("issue_in_ready", {63'd0, in_ready}, 0);
    for (int h = 0; h < int'(v.hold); h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, op_valid}, 1);
      chk("hold_in_ready", {63'd0, in_ready}, 0);
      chk("hold_a", {32'd0, op_a}, {32'd0, v.a});
      chk("hold_b", {32'd0, op_b}, {32'd0, v.b});
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    chk("post_valid", {63'd0, op_valid}, 0);
    chk("post_in_ready", {63'd0, in_ready}, 1);
    chk("post_busy", {63'd0, busy}, 0);
  endtask
  task automatic reset_state(input string nm);
    chk({nm, "_in_ready"}, {63'd0, in_ready}, 1);
    chk({nm, "_op_valid"}, {63'd0, op_valid}, 0);
    chk({nm, "_err"}, {63'd0, err}, 0);
    chk({nm, "_busy"}, {63'd0, busy}, 0);
    chk({nm, "_op_code"}, {62'd0, op_code}, 0);
    chk({nm, "_op_ab"}, {op_a, op_b}, 0);
  endtask
  initial begin
    vec[0] = '{8'h80, 64'h0807060504030201, 1'b0, 4'd0, 2'd0, 32'h04030201, 32'h08070605};
    vec[1] = '{8'h81, 64'h1817161514131211, 1'b0, 4'd0, 2'd1, 32'h14131211, 32'h18171615};
    vec[2] = '{8'hBE, 64'hA0B0C0D0E0F0FFEE, 1'b0, 4'd5, 2'd2, 32'hE0F0FFEE, 32'hA0B0C0D0};
    vec[3] = '{8'h83, 64'h0807060504030201, 1'b1, 4'd1, 2'd3, 32'h04030201, 32'h08070605};
    #12;
    reset_state("rst_hold");
    @(posedge clk); #1;
    rst = 1'b0;
    reset_state("rst_rel");
    frame(vec[0], 8'h00, 1'b1);
    send(8'h43, 1'b0);
    chk("bad_sync_err", {63'd0, err}, 1);
    chk("bad_sync_busy", {63'd0, busy}, 0);
    @(posedge clk); #1;
    chk("bad_sync_err_once", {63'd0, err}, 0);
    for (int i = 1; i < 4; i++) frame(vec[i], 8'h00, 1'b1);
    send(8'h80, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    chk("mid_busy", {63'd0, busy}, 1);
    rst = 1'b1;
    #1;
    reset_state("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    frame(vec[1], 8'h00, 1'b1);
`ifdef MMPU_LOADER_CHECKSUM_EN
    send(8'h80, 1'b0);
    for (int k = 0; k < 8; k++) send(vec[0].d[k*8 +: 8], 1'b0);
    send(8'h89, 1'b0);
    chk("cks_err", {63'd0, err}, 1);
    chk("cks_no_valid", {63'd0, op_valid}, 0);
    @(posedge clk); #1;
    chk("cks_idle", {63'd0, busy}, 0);
`endif
    repeat (2) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
